// File: rtl/izh_spike_synapse_pkg.sv
// Shared float32 field definitions and FSM state encoding for the spike synapse.
package izh_spike_synapse_pkg;

  localparam logic [31:0] FP_ZERO   = 32'h0000_0000;
  localparam int unsigned FP_SIGN   = 31;
  localparam int unsigned FP_EXP_HI = 30;
  localparam int unsigned FP_EXP_LO = 23;
  localparam int unsigned FP_MAN_HI = 22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DECAY
  } state_e;

  function automatic logic [7:0] fp_exp(input logic [31:0] f);
    return f[FP_EXP_HI:FP_EXP_LO];
  endfunction

endpackage

// File: rtl/izh_fp_add.sv
// Combinational float32 adder, round-to-nearest-even, denormals flushed to +0.
module izh_fp_add
  import izh_spike_synapse_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic [31:0] x_big, x_sml;
  logic [7:0]  e_big, e_sml, e_diff;
  logic [26:0] m_big, m_sml, m_shf, norm;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [9:0]  e_res, e_fin;
  logic [24:0] m_rnd;
  logic        rnd_up;

  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      x_big = a;
      x_sml = b;
    end else begin
      x_big = b;
      x_sml = a;
    end
    e_big  = fp_exp(x_big);
    e_sml  = fp_exp(x_sml);
    m_big  = (e_big == '0) ? '0 : {1'b1, x_big[FP_MAN_HI:0], 3'b000};
    m_sml  = (e_sml == '0) ? '0 : {1'b1, x_sml[FP_MAN_HI:0], 3'b000};
    e_diff = e_big - e_sml;
    // Alignment keeps guard/round bits plus a sticky OR of everything shifted out
    if (e_diff > 8'd26) m_shf = {26'd0, |m_sml};
    else m_shf = (m_sml >> e_diff) | {26'd0, |(m_sml & ((27'd1 << e_diff) - 27'd1))};
    if (x_big[FP_SIGN] != x_sml[FP_SIGN]) sum = {1'b0, m_big} - {1'b0, m_shf};
    else sum = {1'b0, m_big} + {1'b0, m_shf};
    lz = '0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (sum[i]) lz = 5'(26 - i);
    end
    if (sum[27]) begin
      norm  = sum[27:1] | {26'd0, sum[0]};
      e_res = {2'b00, e_big} + 10'd1;
    end else begin
      norm  = sum[26:0] << lz;
      e_res = {2'b00, e_big} - {5'd0, lz};
    end
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    m_rnd  = {1'b0, norm[26:3]} + {24'd0, rnd_up};
    e_fin  = e_res + {9'd0, m_rnd[24]};
    if (!(m_rnd[24] | m_rnd[23]) || e_res[9] || e_res == '0) y = FP_ZERO;
    else if (e_fin >= 10'd255) y = {x_big[FP_SIGN], 8'hFF, 23'd0};
    else y = {x_big[FP_SIGN], e_fin[7:0], m_rnd[24] ? 23'd0 : m_rnd[22:0]};
  end

endmodule

// File: rtl/izh_spike_fifo.sv
// Spike event FIFO: power-of-2 depth, wrapping pointers, occupancy output, no bypass.
module izh_spike_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    full     = level_q == (AW+1)'(DEPTH);
    empty    = level_q == '0;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d  = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/izh_spike_synapse.sv
// Spike synapse: buffers presynaptic events, looks up float32 weights and accumulates them
// into a decaying synaptic current, one shared float add per cycle.
module izh_spike_synapse
  import izh_spike_synapse_pkg::*;
#(
  parameter int unsigned SRC_W     = 4,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned TAU_SHIFT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spike_valid,
  output logic                   spike_ready,
  input  logic [SRC_W-1:0]       spike_src,
  input  logic                   acc_en,
  input  logic                   w_we,
  input  logic [SRC_W-1:0]       w_addr,
  input  logic [31:0]            w_data,
  input  logic                   step,
  output logic [31:0]            i_syn,
  output logic                   i_upd,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int unsigned N_W = 2**SRC_W;
  typedef logic [$clog2(DEPTH):0] lvl_t;

  logic [31:0]      w_q [N_W];
  state_e           state_q, state_d;
  logic [31:0]      i_syn_q, i_syn_d, add_b, add_y, decay_t;
  logic             i_upd_q, i_upd_d, step_pending_q, step_pending_d;
  logic             fifo_full, fifo_empty, pop, decay_flush;
  logic [SRC_W-1:0] head_src;
  lvl_t             level;

  izh_spike_fifo #(.DEPTH(DEPTH), .WIDTH(SRC_W)) u_fifo (
    .clk(clk), .rst(rst), .push(spike_valid), .pop(pop), .din(spike_src),
    .dout(head_src), .full(fifo_full), .empty(fifo_empty), .level(level)
  );

  izh_fp_add u_add (.a(i_syn_q), .b(add_b), .y(add_y));

  always_comb begin
    // Decay term is -i_syn * 2**-TAU_SHIFT, built by exponent subtraction and sign flip
    decay_flush    = fp_exp(i_syn_q) <= 8'(TAU_SHIFT);
    decay_t        = {~i_syn_q[FP_SIGN], fp_exp(i_syn_q) - 8'(TAU_SHIFT), i_syn_q[FP_MAN_HI:0]};
    add_b          = (state_q == ST_ACCUM) ? w_q[head_src] : decay_t;
    pop            = state_q == ST_ACCUM;
    step_pending_d = step || (step_pending_q && state_q != ST_DECAY);
    i_syn_d        = i_syn_q;
    i_upd_d        = 1'b0;
    state_d        = ST_IDLE;
    unique case (state_q)
      ST_IDLE: begin
        if (step_pending_q) state_d = ST_DECAY;
        else if (acc_en && !fifo_empty) state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        i_syn_d = add_y;
        i_upd_d = 1'b1;
        if (step_pending_q) state_d = ST_DECAY;
        else if (acc_en && level > lvl_t'(1)) state_d = ST_ACCUM;
      end
      ST_DECAY: begin
        i_syn_d = decay_flush ? FP_ZERO : add_y;
        i_upd_d = 1'b1;
        if (acc_en && !fifo_empty) state_d = ST_ACCUM;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_W; i++) w_q[i] <= FP_ZERO;
      state_q        <= ST_IDLE;
      i_syn_q        <= FP_ZERO;
      i_upd_q        <= 1'b0;
      step_pending_q <= 1'b0;
    end else begin
      if (w_we) w_q[w_addr] <= w_data;
      state_q        <= state_d;
      i_syn_q        <= i_syn_d;
      i_upd_q        <= i_upd_d;
      step_pending_q <= step_pending_d;
    end
  end

  assign spike_ready = !fifo_full;
  assign i_syn       = i_syn_q;
  assign i_upd       = i_upd_q;
  assign fifo_level  = level;

endmodule

// File: tb/tb_izh_spike_synapse.sv
// Bench for izh_spike_synapse: vector table plus scoreboard queue of expected i_syn updates.
module tb_izh_spike_synapse;
  localparam int SRC_W = 4;
  localparam int DEPTH = 8;
  localparam int TAU   = 1;

  logic                   clk = 1'b0;
  logic                   rst, spike_valid, spike_ready, acc_en, w_we, step, i_upd;
  logic [SRC_W-1:0]       spike_src, w_addr;
  logic [31:0]            w_data, i_syn;
  logic [$clog2(DEPTH):0] fifo_level;

  always #5 clk = ~clk;

  izh_spike_synapse #(.SRC_W(SRC_W), .DEPTH(DEPTH), .TAU_SHIFT(TAU)) dut (
    .clk(clk), .rst(rst), .spike_valid(spike_valid), .spike_ready(spike_ready),
    .spike_src(spike_src), .acc_en(acc_en), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .step(step), .i_syn(i_syn), .i_upd(i_upd), .fifo_level(fifo_level)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_upd = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    bit               is_step;
    logic [SRC_W-1:0] src;
    logic [31:0]      exp_isyn;
  } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && i_upd) begin
      n_upd++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_upd: i_syn %h, want no update", i_syn);
      end else begin
        check("i_syn_upd", i_syn, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_w(input logic [SRC_W-1:0] a, input logic [31:0] d);
    w_we = 1'b1; w_addr = a; w_data = d;
    tick();
    w_we = 1'b0;
  endtask

  task automatic push_ev(input logic [SRC_W-1:0] s);
    spike_valid = 1'b1; spike_src = s;
    tick();
    spike_valid = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: %0d updates still missing after 40 cycles, want 0", name, exp_q.size());
      exp_q.delete();
    end
    tick(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    int acc;
    vecs[0]  = '{0, 4'd3, 32'h4000_0000};
    vecs[1]  = '{0, 4'd3, 32'h4080_0000};
    vecs[2]  = '{0, 4'd3, 32'h40C0_0000};
    vecs[3]  = '{1, 4'd0, 32'h4040_0000};
    vecs[4]  = '{0, 4'd1, 32'h3F80_0000};
    vecs[5]  = '{0, 4'd1, 32'hBF80_0000};
    vecs[6]  = '{0, 4'd2, 32'h0000_0000};
    vecs[7]  = '{0, 4'd5, 32'h3F00_0000};
    vecs[8]  = '{0, 4'd7, 32'h3E80_0000};
    vecs[9]  = '{1, 4'd0, 32'h3E00_0000};
    vecs[10] = '{0, 4'd1, 32'hBFF0_0000};
    vecs[11] = '{1, 4'd0, 32'hBF70_0000};
    vecs[12] = '{0, 4'd2, 32'h3D80_0000};
    vecs[13] = '{1, 4'd0, 32'h3D00_0000};

    rst = 1'b1; spike_valid = 1'b0; spike_src = '0; acc_en = 1'b0;
    w_we = 1'b0; w_addr = '0; w_data = '0; step = 1'b0;
    tick(3);
    rst = 1'b0;
    tick();
    check("rst_i_syn", i_syn, 32'h0);
    check("rst_i_upd", 32'(i_upd), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(spike_ready), 32'd1);

    write_w(4'd3, 32'h4000_0000);
    write_w(4'd1, 32'hC000_0000);
    write_w(4'd2, 32'h3F80_0000);
    write_w(4'd5, 32'h3F00_0000);
    write_w(4'd7, 32'hBE80_0000);
    acc_en = 1'b1;
    n_upd = 0;
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(vecs[i].exp_isyn);
      if (vecs[i].is_step) do_step();
      else push_ev(vecs[i].src);
      drain($sformatf("vec%0d", i));
      if (i == 2) check("three_upd_pulses", 32'(n_upd), 32'd3);
    end
    check("table_upd_count", 32'(n_upd), 32'd14);

    // Backpressure: FIFO fills to DEPTH with accumulation held off
    do_reset();
    write_w(4'd3, 32'h4000_0000);
    acc_en = 1'b0;
    acc = 0;
    spike_valid = 1'b1; spike_src = 4'd3;
    for (int i = 0; i < 9; i++) begin
      if (spike_ready) acc++;
      tick();
    end
    spike_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd8);
    check("bp_ready", 32'(spike_ready), 32'd0);
    check("bp_level", 32'(fifo_level), 32'd8);
    check("bp_i_syn_held", i_syn, 32'h0);
    exp_q.push_back(32'h4000_0000); exp_q.push_back(32'h4080_0000);
    exp_q.push_back(32'h40C0_0000); exp_q.push_back(32'h4100_0000);
    exp_q.push_back(32'h4120_0000); exp_q.push_back(32'h4140_0000);
    exp_q.push_back(32'h4160_0000); exp_q.push_back(32'h4180_0000);
    acc_en = 1'b1;
    drain("bp_drain");
    check("bp_level_after", 32'(fifo_level), 32'd0);
    check("bp_ready_after", 32'(spike_ready), 32'd1);

    // Event and step latencies from IDLE
    do_reset();
    write_w(4'd3, 32'h4000_0000);
    acc_en = 1'b1;
    exp_q.push_back(32'h4000_0000);
    spike_valid = 1'b1; spike_src = 4'd3;
    @(posedge clk); #1 spike_valid = 1'b0;
    @(posedge clk); #1 check("ev_lat_edge1", 32'(i_upd), 32'd0);
    @(posedge clk); #1 check("ev_lat_edge2", 32'(i_upd), 32'd1);
    drain("ev_lat");
    exp_q.push_back(32'h3F80_0000);
    step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    @(posedge clk); #1 check("step_lat_edge1", 32'(i_upd), 32'd0);
    @(posedge clk); #1 check("step_lat_edge2", 32'(i_upd), 32'd1);
    drain("step_lat");

    // Step and push together: decay must precede the accumulation
    exp_q.push_back(32'h3F00_0000);
    exp_q.push_back(32'h4020_0000);
    step = 1'b1; spike_valid = 1'b1; spike_src = 4'd3;
    tick();
    step = 1'b0; spike_valid = 1'b0;
    drain("step_before_accum");

    // Weight rewritten during the ACCUM reading it: old value used, new one afterwards
    exp_q.push_back(32'h4090_0000);
    spike_valid = 1'b1; spike_src = 4'd3;
    @(posedge clk); #1 spike_valid = 1'b0;
    @(posedge clk); #1 w_we = 1'b1; w_addr = 4'd3; w_data = 32'h3F80_0000;
    @(posedge clk); #1 w_we = 1'b0;
    drain("w_old");
    exp_q.push_back(32'h40B0_0000);
    push_ev(4'd3);
    drain("w_new");

    // Flush of tiny values and decay of zero
    do_reset();
    write_w(4'd4, 32'h0080_0000);
    write_w(4'd6, 32'h8000_0000);
    exp_q.push_back(32'h0080_0000);
    push_ev(4'd4);
    drain("tiny_accum");
    exp_q.push_back(32'h0000_0000);
    do_step();
    drain("tiny_flush");
    exp_q.push_back(32'h0000_0000);
    push_ev(4'd6);
    drain("neg_zero_accum");
    exp_q.push_back(32'h0000_0000);
    do_step();
    drain("zero_decay");

    // Reset while accumulating
    acc_en = 1'b0;
    write_w(4'd3, 32'h4000_0000);
    push_ev(4'd3); push_ev(4'd3); push_ev(4'd3);
    exp_q.push_back(32'h4000_0000);
    acc_en = 1'b1;
    tick(2);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    check("mid_rst_i_syn", i_syn, 32'h0);
    check("mid_rst_i_upd", 32'(i_upd), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_ready", 32'(spike_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(32'h0000_0000);
    push_ev(4'd3);
    drain("weights_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
